// File: rtl/decode_pkg.sv
// rtl/decode_pkg.sv - RV32I opcodes, instruction formats and immediate generation
package decode_pkg;

    localparam logic [6:0] OP     = 7'h33;
    localparam logic [6:0] OP_IMM = 7'h13;
    localparam logic [6:0] LOAD   = 7'h03;
    localparam logic [6:0] STORE  = 7'h23;
    localparam logic [6:0] BRANCH = 7'h63;
    localparam logic [6:0] JAL    = 7'h6F;
    localparam logic [6:0] JALR   = 7'h67;
    localparam logic [6:0] LUI    = 7'h37;
    localparam logic [6:0] AUIPC  = 7'h17;

    typedef enum logic [2:0] {
        FMT_R,
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J,
        FMT_BAD
    } fmt_t;

    function automatic fmt_t fmt_of(input logic [6:0] opcode);
        case (opcode)
            OP:                  fmt_of = FMT_R;
            OP_IMM, LOAD, JALR:  fmt_of = FMT_I;
            STORE:               fmt_of = FMT_S;
            BRANCH:              fmt_of = FMT_B;
            LUI, AUIPC:          fmt_of = FMT_U;
            JAL:                 fmt_of = FMT_J;
            default:             fmt_of = FMT_BAD;
        endcase
    endfunction

    // Sign-extended 32-bit immediate; R-format and unknown opcodes yield zero
    function automatic logic [31:0] imm_gen(input logic [31:0] instr, input fmt_t fmt);
        case (fmt)
            FMT_I:   imm_gen = {{20{instr[31]}}, instr[31:20]};
            FMT_S:   imm_gen = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            FMT_B:   imm_gen = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            FMT_U:   imm_gen = {instr[31:12], 12'b0};
            FMT_J:   imm_gen = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm_gen = 32'h0;
        endcase
    endfunction

endpackage

// File: rtl/rv_scoreboard.sv
// rtl/rv_scoreboard.sv - per-register busy bits for in-flight writers
module rv_scoreboard #(
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  set_en,
    input  logic [ADDR_WIDTH-1:0] set_sel,
    input  logic                  clr_en,
    input  logic [ADDR_WIDTH-1:0] clr_sel,
    input  logic                  kill_en,
    input  logic [ADDR_WIDTH-1:0] kill_sel,
    input  logic [ADDR_WIDTH-1:0] look_sel1,
    input  logic [ADDR_WIDTH-1:0] look_sel2,
    input  logic [ADDR_WIDTH-1:0] look_sel3,
    output logic                  look_busy1,
    output logic                  look_busy2,
    output logic                  look_busy3
);

    localparam int NREG = 1 << ADDR_WIDTH;

    logic [NREG-1:1] busy;
    logic [NREG-1:0] busy_ext;

    // x0 reads as never busy
    assign busy_ext   = {busy, 1'b0};
    assign look_busy1 = busy_ext[look_sel1];
    assign look_busy2 = busy_ext[look_sel2];
    assign look_busy3 = busy_ext[look_sel3];

    // A new writer setting a register wins over a retire or flush clearing it
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            busy <= '0;
        end else begin
            for (int i = 1; i < NREG; i++) begin
                if (set_en && set_sel == ADDR_WIDTH'(i))
                    busy[i] <= 1'b1;
                else if ((clr_en && clr_sel == ADDR_WIDTH'(i)) ||
                         (kill_en && kill_sel == ADDR_WIDTH'(i)))
                    busy[i] <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/decode_issue.sv
// rtl/decode_issue.sv - RV32I decode/issue stage with hazard scoreboard and ID/EX register
module decode_issue
    import decode_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int PC_WIDTH   = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  if_valid,
    output logic                  if_ready,
    input  logic [31:0]           if_instr,
    input  logic [PC_WIDTH-1:0]   if_pc,
    output logic [ADDR_WIDTH-1:0] read_sel1,
    output logic [ADDR_WIDTH-1:0] read_sel2,
    input  logic [DATA_WIDTH-1:0] read_data1,
    input  logic [DATA_WIDTH-1:0] read_data2,
    input  logic                  wb_valid,
    input  logic [ADDR_WIDTH-1:0] wb_sel,
    input  logic [DATA_WIDTH-1:0] wb_data,
    input  logic                  flush,
    output logic                  ex_valid,
    input  logic                  ex_ready,
    output logic [PC_WIDTH-1:0]   ex_pc,
    output logic [6:0]            ex_opcode,
    output logic [2:0]            ex_funct3,
    output logic [6:0]            ex_funct7,
    output logic [DATA_WIDTH-1:0] ex_rs1_data,
    output logic [DATA_WIDTH-1:0] ex_rs2_data,
    output logic [DATA_WIDTH-1:0] ex_imm,
    output logic [ADDR_WIDTH-1:0] ex_rd,
    output logic                  ex_rd_wen,
    output logic                  ex_illegal
);

    logic [6:0]            opcode;
    fmt_t                  fmt;
    logic [ADDR_WIDTH-1:0] rs1, rs2, rd;
    logic                  rs2_used, illegal, rd_wen;
    logic                  busy1, busy2, busy_rd;
    logic                  byp1, byp2, byp_rd, hazard, issue;
    logic [DATA_WIDTH-1:0] op1, op2, imm;

    assign opcode   = if_instr[6:0];
    assign fmt      = fmt_of(opcode);
    assign rs1      = ADDR_WIDTH'(if_instr[19:15]);
    assign rs2      = ADDR_WIDTH'(if_instr[24:20]);
    assign rd       = ADDR_WIDTH'(if_instr[11:7]);
    assign rs2_used = (fmt == FMT_R) || (fmt == FMT_S) || (fmt == FMT_B);
    assign illegal  = (fmt == FMT_BAD);
    assign rd_wen   = !((fmt == FMT_S) || (fmt == FMT_B) || illegal) && (rd != '0);

    assign read_sel1 = rs1;
    assign read_sel2 = rs2;

    // Retiring writer forwards its data and resolves the hazard in the same cycle
    assign byp1   = wb_valid && (wb_sel == rs1) && (rs1 != '0);
    assign byp2   = wb_valid && (wb_sel == rs2) && (rs2 != '0);
    assign byp_rd = wb_valid && (wb_sel == rd);
    assign op1    = byp1 ? wb_data : read_data1;
    assign op2    = byp2 ? wb_data : read_data2;
    assign imm    = DATA_WIDTH'($signed(imm_gen(if_instr, fmt)));

    assign hazard = if_valid && (((rs1 != '0) && busy1 && !byp1) ||
                                 (rs2_used && (rs2 != '0) && busy2 && !byp2) ||
                                 (rd_wen && busy_rd && !byp_rd));

    assign if_ready = !reset && !hazard && (!ex_valid || ex_ready) && !flush;
    assign issue    = if_valid && if_ready;

    rv_scoreboard #(.ADDR_WIDTH(ADDR_WIDTH)) u_scoreboard (
        .clock      (clock),
        .reset      (reset),
        .set_en     (issue && rd_wen),
        .set_sel    (rd),
        .clr_en     (wb_valid),
        .clr_sel    (wb_sel),
        .kill_en    (flush && ex_valid && ex_rd_wen),
        .kill_sel   (ex_rd),
        .look_sel1  (rs1),
        .look_sel2  (rs2),
        .look_sel3  (rd),
        .look_busy1 (busy1),
        .look_busy2 (busy2),
        .look_busy3 (busy_rd)
    );

    // ID/EX register: load on issue, drop on flush or consumption, hold while stalled
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ex_valid    <= 1'b0;
            ex_pc       <= '0;
            ex_opcode   <= '0;
            ex_funct3   <= '0;
            ex_funct7   <= '0;
            ex_rs1_data <= '0;
            ex_rs2_data <= '0;
            ex_imm      <= '0;
            ex_rd       <= '0;
            ex_rd_wen   <= 1'b0;
            ex_illegal  <= 1'b0;
        end else if (issue) begin
            ex_valid    <= 1'b1;
            ex_pc       <= if_pc;
            ex_opcode   <= opcode;
            ex_funct3   <= if_instr[14:12];
            ex_funct7   <= if_instr[31:25];
            ex_rs1_data <= op1;
            ex_rs2_data <= op2;
            ex_imm      <= imm;
            ex_rd       <= rd;
            ex_rd_wen   <= rd_wen;
            ex_illegal  <= illegal;
        end else if (flush || (ex_valid && ex_ready)) begin
            ex_valid    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_decode_issue.sv
// tb/tb_decode_issue.sv - directed self-checking bench for decode_issue
module tb_decode_issue;

    logic        clock = 1'b0;
    logic        reset;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [4:0]  read_sel1, read_sel2;
    logic [31:0] read_data1, read_data2;
    logic        wb_valid;
    logic [4:0]  wb_sel;
    logic [31:0] wb_data;
    logic        flush;
    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] ex_pc;
    logic [6:0]  ex_opcode;
    logic [2:0]  ex_funct3;
    logic [6:0]  ex_funct7;
    logic [31:0] ex_rs1_data, ex_rs2_data, ex_imm;
    logic [4:0]  ex_rd;
    logic        ex_rd_wen;
    logic        ex_illegal;

    logic [31:1] exp_busy;
    int          tests  = 0;
    int          failed = 0;

    always #5 clock = ~clock;

    // Register file model: xN reads 0x100+N, x0 reads zero
    always_comb begin
        read_data1 = (read_sel1 == 5'd0) ? 32'h0 : 32'h100 + {27'h0, read_sel1};
        read_data2 = (read_sel2 == 5'd0) ? 32'h0 : 32'h100 + {27'h0, read_sel2};
    end

    decode_issue dut (
        .clock(clock), .reset(reset), .if_valid(if_valid), .if_ready(if_ready),
        .if_instr(if_instr), .if_pc(if_pc), .read_sel1(read_sel1), .read_sel2(read_sel2),
        .read_data1(read_data1), .read_data2(read_data2), .wb_valid(wb_valid),
        .wb_sel(wb_sel), .wb_data(wb_data), .flush(flush), .ex_valid(ex_valid),
        .ex_ready(ex_ready), .ex_pc(ex_pc), .ex_opcode(ex_opcode), .ex_funct3(ex_funct3),
        .ex_funct7(ex_funct7), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
        .ex_imm(ex_imm), .ex_rd(ex_rd), .ex_rd_wen(ex_rd_wen), .ex_illegal(ex_illegal)
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic mid();
        #3;
    endtask

    task automatic test_reset();
        reset = 1'b1; if_valid = 1'b1; if_instr = 32'h00500093; if_pc = 32'h1000;
        wb_valid = 1'b0; wb_sel = '0; wb_data = '0; flush = 1'b0; ex_ready = 1'b1;
        exp_busy = '0;
        step(); step(); mid();
        tests++; if (ex_valid !== 1'b0) begin failed++; $display("FAIL reset_ex_valid got %0b exp 0", ex_valid); end
        tests++; if (if_ready !== 1'b0) begin failed++; $display("FAIL reset_if_ready got %0b exp 0", if_ready); end
        tests++; if (dut.u_scoreboard.busy !== exp_busy) begin failed++; $display("FAIL reset_busy got %h exp %h", dut.u_scoreboard.busy, exp_busy); end
        tests++; if (ex_imm !== 32'h0) begin failed++; $display("FAIL reset_ex_imm got %h exp 0", ex_imm); end
        step();
        reset = 1'b0;
        mid();
        tests++; if (if_ready !== 1'b1) begin failed++; $display("FAIL addi_if_ready got %0b exp 1", if_ready); end
        step();
        exp_busy[1] = 1'b1;
        tests++; if (ex_valid !== 1'b1) begin failed++; $display("FAIL addi_ex_valid got %0b exp 1", ex_valid); end
        tests++; if (ex_imm !== 32'd5) begin failed++; $display("FAIL addi_ex_imm got %h exp 5", ex_imm); end
        tests++; if (ex_rd !== 5'd1 || ex_rd_wen !== 1'b1) begin failed++; $display("FAIL addi_rd got rd=%0d wen=%0b exp rd=1 wen=1", ex_rd, ex_rd_wen); end
        tests++; if (ex_opcode !== 7'h13 || ex_pc !== 32'h1000 || ex_rs1_data !== 32'h0) begin failed++; $display("FAIL addi_payload got op=%h pc=%h rs1=%h exp 13 1000 0", ex_opcode, ex_pc, ex_rs1_data); end
        tests++; if (dut.u_scoreboard.busy !== exp_busy) begin failed++; $display("FAIL addi_busy got %h exp %h", dut.u_scoreboard.busy, exp_busy); end
    endtask

    task automatic test_bypass();
        if_instr = 32'h002081B3; if_pc = 32'h1004;   // ADD x3,x1,x2
        mid();
        tests++; if (if_ready !== 1'b0) begin failed++; $display("FAIL raw_stall_if_ready got %0b exp 0", if_ready); end
        step();
        tests++; if (ex_valid !== 1'b0) begin failed++; $display("FAIL raw_bubble_ex_valid got %0b exp 0", ex_valid); end
        wb_valid = 1'b1; wb_sel = 5'd1; wb_data = 32'h3F;
        mid();
        tests++; if (if_ready !== 1'b1) begin failed++; $display("FAIL bypass_if_ready got %0b exp 1", if_ready); end
        step();
        wb_valid = 1'b0;
        exp_busy[1] = 1'b0; exp_busy[3] = 1'b1;
        tests++; if (ex_rs1_data !== 32'h3F || ex_rs2_data !== 32'h102) begin failed++; $display("FAIL bypass_operands got %h %h exp 3f 102", ex_rs1_data, ex_rs2_data); end
        tests++; if (ex_opcode !== 7'h33 || ex_rd !== 5'd3 || ex_imm !== 32'h0) begin failed++; $display("FAIL add_payload got op=%h rd=%0d imm=%h exp 33 3 0", ex_opcode, ex_rd, ex_imm); end
        tests++; if (dut.u_scoreboard.busy !== exp_busy) begin failed++; $display("FAIL bypass_busy got %h exp %h", dut.u_scoreboard.busy, exp_busy); end
    endtask

    task automatic test_store_branch();
        if_instr = 32'h0020A423; if_pc = 32'h1008;   // SW x2,8(x1)
        step();
        tests++; if (ex_imm !== 32'd8 || ex_rd_wen !== 1'b0 || ex_funct3 !== 3'd2) begin failed++; $display("FAIL sw_decode got imm=%h wen=%0b f3=%0d exp 8 0 2", ex_imm, ex_rd_wen, ex_funct3); end
        tests++; if (dut.u_scoreboard.busy !== exp_busy) begin failed++; $display("FAIL sw_busy got %h exp %h", dut.u_scoreboard.busy, exp_busy); end
        if_instr = 32'hFE000EE3; if_pc = 32'h100C;   // BEQ x0,x0,-4
        step();
        tests++; if (ex_imm !== 32'hFFFFFFFC || ex_rd_wen !== 1'b0 || ex_funct7 !== 7'h7F) begin failed++; $display("FAIL beq_decode got imm=%h wen=%0b f7=%h exp fffffffc 0 7f", ex_imm, ex_rd_wen, ex_funct7); end
    endtask

    task automatic test_back_to_back();
        if_instr = 32'h00700313; if_pc = 32'h1010;   // ADDI x6,x0,7
        step();
        exp_busy[6] = 1'b1;
        ex_ready = 1'b0;
        if_instr = 32'h00900393; if_pc = 32'h1014;   // ADDI x7,x0,9
        for (int i = 0; i < 3; i++) begin
            mid();
            tests++; if (if_ready !== 1'b0) begin failed++; $display("FAIL stall_if_ready[%0d] got %0b exp 0", i, if_ready); end
            step();
            tests++; if (ex_valid !== 1'b1 || ex_rd !== 5'd6 || ex_imm !== 32'd7 || ex_pc !== 32'h1010) begin failed++; $display("FAIL stall_payload[%0d] got v=%0b rd=%0d imm=%h pc=%h exp 1 6 7 1010", i, ex_valid, ex_rd, ex_imm, ex_pc); end
        end
        ex_ready = 1'b1;
        mid();
        tests++; if (if_ready !== 1'b1) begin failed++; $display("FAIL release_if_ready got %0b exp 1", if_ready); end
        step();
        exp_busy[7] = 1'b1;
        tests++; if (ex_valid !== 1'b1 || ex_rd !== 5'd7 || ex_imm !== 32'd9) begin failed++; $display("FAIL b2b_payload got v=%0b rd=%0d imm=%h exp 1 7 9", ex_valid, ex_rd, ex_imm); end
        if_valid = 1'b0;
        step();
        tests++; if (ex_valid !== 1'b0) begin failed++; $display("FAIL drain_ex_valid got %0b exp 0", ex_valid); end
        tests++; if (dut.u_scoreboard.busy !== exp_busy) begin failed++; $display("FAIL b2b_busy got %h exp %h", dut.u_scoreboard.busy, exp_busy); end
    endtask

    task automatic test_flush();
        if_valid = 1'b1; if_instr = 32'h00100213; if_pc = 32'h1018;   // ADDI x4,x0,1
        step();
        exp_busy[4] = 1'b1;
        tests++; if (dut.u_scoreboard.busy[4] !== 1'b1) begin failed++; $display("FAIL pre_flush_busy4 got %0b exp 1", dut.u_scoreboard.busy[4]); end
        flush = 1'b1; if_instr = 32'h00200413; if_pc = 32'h101C;     // ADDI x8,x0,2
        mid();
        tests++; if (if_ready !== 1'b0) begin failed++; $display("FAIL flush_if_ready got %0b exp 0", if_ready); end
        step();
        flush = 1'b0; if_valid = 1'b0;
        exp_busy[4] = 1'b0;
        tests++; if (ex_valid !== 1'b0) begin failed++; $display("FAIL flush_ex_valid got %0b exp 0", ex_valid); end
        tests++; if (dut.u_scoreboard.busy !== exp_busy) begin failed++; $display("FAIL flush_busy got %h exp %h", dut.u_scoreboard.busy, exp_busy); end
    endtask

    task automatic test_same_cycle_and_illegal();
        if_valid = 1'b1; if_instr = 32'h00300293; if_pc = 32'h1020;   // ADDI x5,x0,3
        step();
        exp_busy[5] = 1'b1;
        if_instr = 32'h00400293; if_pc = 32'h1024;                    // ADDI x5,x0,4
        wb_valid = 1'b1; wb_sel = 5'd5; wb_data = 32'h55;
        mid();
        tests++; if (if_ready !== 1'b1) begin failed++; $display("FAIL waw_wb_if_ready got %0b exp 1", if_ready); end
        step();
        wb_valid = 1'b0;
        tests++; if (dut.u_scoreboard.busy !== exp_busy) begin failed++; $display("FAIL set_wins_busy got %h exp %h", dut.u_scoreboard.busy, exp_busy); end
        tests++; if (ex_imm !== 32'd4 || ex_rd !== 5'd5) begin failed++; $display("FAIL waw_payload got imm=%h rd=%0d exp 4 5", ex_imm, ex_rd); end
        if_instr = 32'h000004FF; if_pc = 32'h1028;                    // opcode 0x7F, rd=x9
        step();
        if_valid = 1'b0;
        tests++; if (ex_valid !== 1'b1 || ex_illegal !== 1'b1 || ex_rd_wen !== 1'b0 || ex_imm !== 32'h0) begin failed++; $display("FAIL illegal_decode got v=%0b ill=%0b wen=%0b imm=%h exp 1 1 0 0", ex_valid, ex_illegal, ex_rd_wen, ex_imm); end
        tests++; if (dut.u_scoreboard.busy !== exp_busy) begin failed++; $display("FAIL illegal_busy got %h exp %h", dut.u_scoreboard.busy, exp_busy); end
    endtask

    task automatic test_async_reset();
        #2;
        reset = 1'b1;
        #1;
        exp_busy = '0;
        tests++; if (ex_valid !== 1'b0 || ex_illegal !== 1'b0 || ex_pc !== 32'h0) begin failed++; $display("FAIL async_reset_ex got v=%0b ill=%0b pc=%h exp 0 0 0", ex_valid, ex_illegal, ex_pc); end
        tests++; if (dut.u_scoreboard.busy !== exp_busy) begin failed++; $display("FAIL async_reset_busy got %h exp %h", dut.u_scoreboard.busy, exp_busy); end
        step();
        reset = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_store_branch();
        test_back_to_back();
        test_flush();
        test_same_cycle_and_illegal();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
